async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low. clk_in and clk_out are that clock at the same frequency, with arbitrary phase offset (nominally 180 degrees).
REQ-002 Parameter DW, default 140: data word width in bits.
REQ-003 Parameter DEPTH, default 2: number of storage entries; SHALL be a power of two, 2 or more.
REQ-004 clk_in, input, 1: write-side clock; all write logic uses rising edges.
REQ-005 clk_out, input, 1: read-side clock; all read logic uses rising edges.
REQ-006 rst_n, input, 1: asynchronous active-low reset for both sides.
REQ-007 fifo_w_enable, input, 1: write request, sampled on rising clk_in.
REQ-008 fifo_r_enable, input, 1: read (pop) request, sampled on rising clk_out.
REQ-009 data_to_fifo, input, DW: write data.
REQ-010 data_from_fifo, output, DW: head-of-FIFO data.
REQ-011 fifo_empty, output, 1: FIFO empty, in the clk_out domain.
REQ-012 fifo_full, output, 1: FIFO full, in the clk_in domain.

Function
REQ-013 Pointers SHALL be log2(DEPTH)+1 bits wide (address bits plus wrap bit), kept in binary and Gray form per side.
REQ-014 Each Gray pointer SHALL cross to the other side through a 2-flop synchronizer clocked by the destination clock.
REQ-015 Write: on rising clk_in with fifo_w_enable=1 and fifo_full=0:
  - mem[wptr] <= data_to_fifo
  - wptr increments, wrapping modulo 2*DEPTH.
REQ-016 A write request while fifo_full=1 SHALL be ignored: no storage change, no pointer change.
REQ-017 Read: on rising clk_out with fifo_r_enable=1 and fifo_empty=0, rptr increments, wrapping modulo 2*DEPTH.
REQ-018 A read request while fifo_empty=1 SHALL be ignored.
REQ-019 data_from_fifo SHALL be first-word-fall-through: combinationally mem[rptr address bits].
  - The popped word is therefore valid before and at the popping edge.
  - data_from_fifo SHALL hold the same value until rptr advances.
REQ-020 fifo_full SHALL be 1 when write Gray pointer equals synchronized read Gray pointer with the top two bits inverted.
  - It SHALL assert in the same clk_in cycle that the filling write updates wptr.
  - It SHALL deassert no later than 2 clk_in edges after the freeing read.
REQ-021 fifo_empty SHALL be 1 when read Gray pointer equals synchronized write Gray pointer.
  - It SHALL assert in the same clk_out cycle that the last read updates rptr.
  - It SHALL deassert no later than 2 clk_out edges after the first write.
REQ-022 Flags SHALL be pessimistic only: never report not-full when full, never report not-empty when empty.
REQ-023 Simultaneous write and read on a non-full, non-empty FIFO SHALL both complete, and occupancy stays constant.
REQ-024 Pointer wrap-around SHALL be seamless: data order is preserved indefinitely.

Reset
REQ-025 rst_n=0 SHALL immediately clear the following, independent of either clock:
  - all pointers and synchronizer flops
  - all memory entries (to 0)
REQ-026 During reset, outputs SHALL be: fifo_empty=1, fifo_full=0, data_from_fifo=0.
REQ-027 Reset asserted mid-operation (FIFO full) SHALL discard all contents; after release the FIFO is empty and not full.
REQ-028 After rst_n rises, normal operation SHALL begin on the next clock edge of each side.

Verification
REQ-029 Reset 4 cycles, release, wait 2 cycles; write 2 random words; wait 2 clk_in edges -> fifo_full=1, fifo_empty=0.
REQ-030 From full, two single-cycle reads on clk_out, then wait 2 clk_in edges:
  - each read returns the written words in order
  - fifo_full=0, fifo_empty=1.
REQ-031 Fill to full, then pulse rst_n low for 4 cycles and wait 2 edges -> fifo_full=0, fifo_empty=1.
REQ-032 After reset, hold data_to_fifo random with fifo_w_enable=0 for 3 cycles -> fifo_empty=1, fifo_full=0.
  - Then write 0x...A5A5A5A5 and read once -> data_from_fifo=0x...A5A5A5A5 at the read edge.
REQ-033 Run 20 iterations of random write (only if not full) and random read (only if not empty) against a queue model:
  - every popped word matches the model
  - no writes are dropped while not full.
REQ-034 Write to full FIFO, and read from empty FIFO -> no pointer or data change; model unchanged.

Source files
------------

// File: rtl/async_fifo.sv
// Dual-clock FIFO with Gray-coded pointers crossing through 2-flop synchronizers.
// Read data is first-word-fall-through; flags are computed from local and synchronized pointers.
module async_fifo #(
  parameter int DW    = 140,
  parameter int DEPTH = 2
) (
  input  logic          clk_in,
  input  logic          clk_out,
  input  logic          rst_n,
  input  logic          fifo_w_enable,
  input  logic          fifo_r_enable,
  input  logic [DW-1:0] data_to_fifo,
  output logic [DW-1:0] data_from_fifo,
  output logic          fifo_empty,
  output logic          fifo_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // Gray "full" pattern: the read pointer with its two MSBs inverted.
  localparam logic [PW-1:0] GRAY_TOP2 = PW'(3) << (AW - 1);

  logic [DW-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wbin, r_wgray, r_rbin, r_rgray;
  logic [PW-1:0] r_wq1, r_wq2, r_rq1, r_rq2;

  logic          w_wr_fire, w_rd_fire;
  logic [PW-1:0] w_wbin_next, w_wgray_next, w_rbin_next, w_rgray_next;

  assign w_wr_fire    = fifo_w_enable && !fifo_full;
  assign w_wbin_next  = r_wbin + PW'(w_wr_fire);
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  assign w_rd_fire    = fifo_r_enable && !fifo_empty;
  assign w_rbin_next  = r_rbin + PW'(w_rd_fire);
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin  <= '0;
      r_wgray <= '0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
    end
  end

  // NOTE: storage is reset because the combinational read port must present 0 while in reset.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_fire) begin
      r_mem[r_wbin[AW-1:0]] <= data_to_fifo;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rq1 <= '0;
      r_rq2 <= '0;
    end else begin
      r_rq1 <= r_rgray;
      r_rq2 <= r_rq1;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_rbin  <= '0;
      r_rgray <= '0;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rgray <= w_rgray_next;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
    end else begin
      r_wq1 <= r_wgray;
      r_wq2 <= r_wq1;
    end
  end

  assign fifo_full      = (r_wgray == (r_rq2 ^ GRAY_TOP2));
  assign fifo_empty     = (r_rgray == r_wq2);
  assign data_from_fifo = r_mem[r_rbin[AW-1:0]];

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboarded bench for async_fifo: writes push expected words, a monitor checks every pop.
// Directed reset/full/empty scenarios plus a randomized two-clock traffic phase.
module tb_async_fifo;

  localparam int DW    = 140;
  localparam int DEPTH = 2;

  logic          clk_in = 1'b0;
  logic          clk_out = 1'b1;
  logic          rst_n = 1'b0;
  logic          fifo_w_enable = 1'b0;
  logic          fifo_r_enable = 1'b0;
  logic [DW-1:0] data_to_fifo = '0;
  logic [DW-1:0] data_from_fifo;
  logic          fifo_empty, fifo_full;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] pat_a5;

  always #5 clk_in  = ~clk_in;
  always #5 clk_out = ~clk_out;

  async_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_in         (clk_in),
    .clk_out        (clk_out),
    .rst_n          (rst_n),
    .fifo_w_enable  (fifo_w_enable),
    .fifo_r_enable  (fifo_r_enable),
    .data_to_fifo   (data_to_fifo),
    .data_from_fifo (data_from_fifo),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full)
  );

  task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < DW / 32 + 1; i++) w = (w << 32) | DW'($urandom);
    return w;
  endfunction

  // Monitor: a pop happens at the next clk_out rise whenever enable is high and the FIFO is not empty.
  initial begin
    forever begin
      @(negedge clk_out);
      #1;
      if (rst_n && fifo_r_enable && !fifo_empty) begin
        checkb("pop_has_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) checkw("pop_data", data_from_fifo, sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic fill_to_full();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      fifo_w_enable = !fifo_full;
      data_to_fifo  = rand_word();
      if (fifo_w_enable) sb_q.push_back(data_to_fifo);
    end
    @(posedge clk_in); #1;
    fifo_w_enable = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_out); #1;
      fifo_r_enable = !fifo_empty;
    end
    @(posedge clk_out); #1;
    fifo_r_enable = 1'b0;
  endtask

  task automatic wait_not_empty();
    int n = 0;
    @(posedge clk_out); #1;
    while (fifo_empty && n < 20) begin
      @(posedge clk_out); #1;
      n++;
    end
    checkb("wait_not_empty_budget", fifo_empty, 1'b0);
  endtask

  initial begin
    logic [7:0] a5 = 8'hA5;
    for (int i = 0; i < DW; i++) pat_a5[i] = a5[i % 8];

    // Reset values
    repeat (4) @(posedge clk_in);
    #1;
    checkb("rst_empty", fifo_empty, 1'b1);
    checkb("rst_full", fifo_full, 1'b0);
    checkw("rst_data", data_from_fifo, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    // Two writes fill a depth-2 FIFO
    for (int i = 0; i < DEPTH; i++) begin
      fifo_w_enable = 1'b1;
      data_to_fifo  = rand_word();
      sb_q.push_back(data_to_fifo);
      @(posedge clk_in); #1;
    end
    fifo_w_enable = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checkb("full_after_fill", fifo_full, 1'b1);
    checkb("empty_after_fill", fifo_empty, 1'b0);

    // Two single-cycle reads empty it again
    @(posedge clk_out); #1;
    fifo_r_enable = 1'b1;
    repeat (DEPTH) @(posedge clk_out);
    #1;
    fifo_r_enable = 1'b0;
    checkb("empty_right_after_last_read", fifo_empty, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;
    checkb("full_after_reads", fifo_full, 1'b0);
    checkb("empty_after_reads", fifo_empty, 1'b1);
    checki("sb_drained_1", sb_q.size(), 0);

    // Reset while full discards contents
    fill_to_full();
    checkb("full_before_reset", fifo_full, 1'b1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    checkb("async_rst_empty", fifo_empty, 1'b1);
    checkw("async_rst_data", data_from_fifo, '0);
    repeat (4) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    checkb("post_rst_full", fifo_full, 1'b0);
    checkb("post_rst_empty", fifo_empty, 1'b1);
    checkw("post_rst_data", data_from_fifo, '0);

    // Data toggling without write enable has no effect
    for (int i = 0; i < 3; i++) begin
      data_to_fifo = rand_word();
      @(posedge clk_in); #1;
    end
    checkb("noen_empty", fifo_empty, 1'b1);
    checkb("noen_full", fifo_full, 1'b0);

    // Known pattern, read once
    fifo_w_enable = 1'b1;
    data_to_fifo  = pat_a5;
    sb_q.push_back(pat_a5);
    @(posedge clk_in); #1;
    fifo_w_enable = 1'b0;
    wait_not_empty();
    checkw("a5_head", data_from_fifo, pat_a5);
    fifo_r_enable = 1'b1;
    @(posedge clk_out); #1;
    fifo_r_enable = 1'b0;
    checkb("a5_empty_after_read", fifo_empty, 1'b1);

    // Randomized concurrent traffic
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk_in); #1;
          fifo_w_enable = ($urandom_range(0, 1) == 1) && !fifo_full;
          data_to_fifo  = rand_word();
          if (fifo_w_enable) sb_q.push_back(data_to_fifo);
        end
        @(posedge clk_in); #1;
        fifo_w_enable = 1'b0;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk_out); #1;
          fifo_r_enable = ($urandom_range(0, 1) == 1) && !fifo_empty;
        end
        @(posedge clk_out); #1;
        fifo_r_enable = 1'b0;
      end
    join
    drain();
    checki("sb_drained_random", sb_q.size(), 0);
    checkb("random_end_empty", fifo_empty, 1'b1);

    // Read from empty is ignored
    fifo_r_enable = 1'b1;
    repeat (2) @(posedge clk_out);
    #1;
    fifo_r_enable = 1'b0;
    checkb("read_empty_still_empty", fifo_empty, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;
    checkb("read_empty_not_full", fifo_full, 1'b0);

    // Write to full is ignored; drained order proves nothing was overwritten
    fill_to_full();
    checki("fill_count", sb_q.size(), DEPTH);
    fifo_w_enable = 1'b1;
    data_to_fifo  = ~pat_a5;
    @(posedge clk_in); #1;
    fifo_w_enable = 1'b0;
    checkb("write_full_still_full", fifo_full, 1'b1);
    drain();
    checki("sb_drained_final", sb_q.size(), 0);
    checkb("final_empty", fifo_empty, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;
    checkb("final_not_full", fifo_full, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
